// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int INST_W         = 32;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes little-endian into one instruction word.
// The word output already includes a byte accepted in the current cycle.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        byte_data,
  output logic              word_full,
  output logic [INST_W-1:0] word
);

  logic [BYTE_IDX_W-1:0] byte_idx_reg;
  logic [7:0]            lane_reg [BYTES_PER_WORD];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      byte_idx_reg <= '0;
    end else if (accept) begin
      byte_idx_reg <= byte_idx_reg + 1'b1;
    end
  end

  assign word_full = accept && (byte_idx_reg == BYTE_IDX_W'(BYTES_PER_WORD - 1));

  // One register per byte lane; the lane selected by byte_idx captures the byte.
  generate
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      logic lane_hit;
      assign lane_hit = accept && (byte_idx_reg == BYTE_IDX_W'(gi));

      always_ff @(posedge clk) begin
        if (reset || clear) begin
          lane_reg[gi] <= '0;
        end else if (lane_hit) begin
          lane_reg[gi] <= byte_data;
        end
      end

      assign word[8*gi +: 8] = lane_hit ? byte_data : lane_reg[gi];
    end
  endgenerate

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into the instruction memory word by word and holds the core
// in reset until the requested number of words has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [INST_W-1:0] imem_wdata,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  state_t              state;
  logic [ADDR_W:0]     count_q;
  logic [ADDR_W-1:0]   word_idx;

  logic                idle_like;
  logic                start_zero;
  logic                start_bad;
  logic                start_ok;
  logic                accept;
  logic                word_full;
  logic                last_word;
  logic [INST_W-1:0]   pk_word;

  assign idle_like  = (state == IDLE) || (state == DONE);
  assign start_zero = idle_like && start && (word_count == '0);
  assign start_bad  = idle_like && start && (word_count > DEPTH_C);
  assign start_ok   = idle_like && start && (word_count != '0) && !start_bad;
  assign accept     = byte_valid && byte_ready;
  assign last_word  = ({1'b0, word_idx} == (count_q - 1'b1));

  imem_loader_byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_ok),
    .accept    (accept),
    .byte_data (byte_data),
    .word_full (word_full),
    .word      (pk_word)
  );

  // All outputs are registered alongside the state so they reflect the state
  // entered at each edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count_q    <= '0;
      word_idx   <= '0;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      core_hold  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      error   <= 1'b0;
      imem_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_zero) begin
            state      <= DONE;
            byte_ready <= 1'b0;
            core_hold  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
          end else if (start_bad) begin
            error <= 1'b1;
          end else if (start_ok) begin
            state      <= RECV;
            count_q    <= word_count;
            word_idx   <= '0;
            byte_ready <= 1'b1;
            core_hold  <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        RECV: begin
          if (word_full) begin
            state      <= WRITE;
            byte_ready <= 1'b0;
            imem_we    <= 1'b1;
            imem_waddr <= word_idx;
            imem_wdata <= pk_word;
          end
        end
        WRITE: begin
          if (last_word) begin
            state     <= DONE;
            core_hold <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            state      <= RECV;
            word_idx   <= word_idx + 1'b1;
            byte_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: loads, handshake gaps, range checks,
// mid-load reset and a full-depth load followed by a reload.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W:0]   word_count = '0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = '0;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [INST_W-1:0] imem_wdata;
  logic              core_hold;
  logic              busy;
  logic              done;
  logic              error;

  int n_vec = 0;
  int n_bad = 0;
  int ready_gap_err = 0;
  logic [ADDR_W-1:0] log_addr [$];
  logic [31:0]       log_data [$];

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .core_hold  (core_hold),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      log_addr.push_back(imem_waddr);
      log_data.push_back(imem_wdata);
    end
    if (busy && !imem_we && !byte_ready) ready_gap_err++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    log_addr.delete();
    log_data.delete();
  endtask

  // Returns at the negedge following the edge that accepted the byte.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t = 0;
    if (gap) begin
      byte_valid = 1'b0;
      @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("byte_timeout", 32'(t), 32'd0);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic do_start(input int wc);
    start = 1'b1;
    word_count = (ADDR_W + 1)'(wc);
    @(negedge clk);
    start = 1'b0;
  endtask

  // {byte_ready, imem_we, core_hold, busy, done, error}
  function automatic logic [31:0] flags();
    return {26'd0, byte_ready, imem_we, core_hold, busy, done, error};
  endfunction

  logic [7:0] prog [8] = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
  logic [7:0] beef [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

  initial begin
    int errs;
    logic [7:0] w8;

    // Reset state
    do_reset();
    check("rst_flags", flags(), 32'b001000);
    check("rst_waddr", 32'(imem_waddr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);

    // Two-word load, back-to-back bytes
    do_start(2);
    check("recv_flags", flags(), 32'b101100);
    for (int i = 0; i < 8; i++) send_byte(prog[i], 1'b0);
    check("w1_flags", flags(), 32'b011100);
    @(negedge clk);
    check("done_flags", flags(), 32'b000010);
    check("b2b_nwrites", 32'(log_addr.size()), 32'd2);
    if (log_addr.size() == 2) begin
      check("b2b_a0", 32'(log_addr[0]), 32'd0);
      check("b2b_d0", log_data[0], 32'h00500013);
      check("b2b_a1", 32'(log_addr[1]), 32'd1);
      check("b2b_d1", log_data[1], 32'h00100093);
    end

    // Same load from DONE, byte_valid toggled
    log_addr.delete();
    log_data.delete();
    ready_gap_err = 0;
    do_start(2);
    check("restart_hold", 32'(core_hold), 32'd1);
    for (int i = 0; i < 8; i++) send_byte(prog[i], 1'b1);
    @(negedge clk);
    check("tog_done", 32'(done), 32'd1);
    check("tog_nwrites", 32'(log_addr.size()), 32'd2);
    if (log_addr.size() == 2) begin
      check("tog_d0", log_data[0], 32'h00500013);
      check("tog_d1", log_data[1], 32'h00100093);
      check("tog_a1", 32'(log_addr[1]), 32'd1);
    end
    check("tog_ready_gaps", 32'(ready_gap_err), 32'd0);

    // word_count = 0
    do_reset();
    do_start(0);
    check("wc0_flags", flags(), 32'b000010);
    repeat (3) @(negedge clk);
    check("wc0_nwrites", 32'(log_addr.size()), 32'd0);

    // word_count = 65, out of range
    do_reset();
    do_start(65);
    check("wc65_flags", flags(), 32'b001001);
    @(negedge clk);
    check("wc65_after", flags(), 32'b001000);

    // Reset after 6 bytes of a 2-word load
    do_reset();
    do_start(2);
    for (int i = 0; i < 6; i++) send_byte(prog[i], 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_flags", flags(), 32'b001000);
    check("mid_rst_waddr", 32'(imem_waddr), 32'd0);
    check("mid_rst_wdata", imem_wdata, 32'd0);
    byte_valid = 1'b1;
    byte_data  = prog[6];
    repeat (4) @(negedge clk);
    check("mid_rst_ready", 32'(byte_ready), 32'd0);
    byte_valid = 1'b0;
    check("mid_rst_nwrites", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() == 1) check("mid_rst_d0", log_data[0], 32'h00500013);

    // Full 64-word load: word w = {C3, ~w, 5A, w}
    do_reset();
    do_start(64);
    for (int w = 0; w < 64; w++) begin
      w8 = 8'(w);
      send_byte(w8, 1'b0);
      send_byte(8'h5A, 1'b0);
      send_byte(~w8, 1'b0);
      send_byte(8'hC3, 1'b0);
    end
    @(negedge clk);
    check("full_done", flags(), 32'b000010);
    check("full_nwrites", 32'(log_addr.size()), 32'd64);
    if (log_addr.size() == 64) begin
      check("full_last_addr", 32'(log_addr[63]), 32'd63);
      check("full_last_data", log_data[63], 32'hC3C05A3F);
      errs = 0;
      for (int w = 0; w < 64; w++) begin
        w8 = 8'(w);
        if (log_addr[w] !== 6'(w) || log_data[w] !== {8'hC3, ~w8, 8'h5A, w8}) errs++;
      end
      check("full_entries", 32'(errs), 32'd0);
    end

    // Reload from DONE with one word
    log_addr.delete();
    log_data.delete();
    do_start(1);
    check("reload_hold", 32'(core_hold), 32'd1);
    for (int i = 0; i < 4; i++) send_byte(beef[i], 1'b0);
    check("reload_hold_w", 32'(core_hold), 32'd1);
    @(negedge clk);
    check("reload_done", flags(), 32'b000010);
    check("reload_nwrites", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() == 1) begin
      check("reload_a0", 32'(log_addr[0]), 32'd0);
      check("reload_d0", log_data[0], 32'hDEADBEEF);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
